// File: rtl/axi_ar_rr_mux.sv
// rtl/axi_ar_rr_mux.sv - round-robin merge of NUM_MST AXI read-address channels onto one slave AR channel
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   axi_mst_arid      : flattened master ARIDs, master m at [m*AXI_ID_WIDTH +: AXI_ID_WIDTH]
//   axi_mst_araddr    : flattened master ARADDRs, packed the same way
//   axi_mst_arvalid   : per-master ARVALID
//   axi_mst_arready   : per-master ARREADY, one-hot or zero
//   axi_slv_arid      : {master index, original ARID}, index in the MSBs
//   axi_slv_araddr    : registered ARADDR
//   axi_slv_arvalid   : registered ARVALID
//   axi_slv_arready   : slave ARREADY
//   grant_idx         : index of the most recently accepted master

module axi_ar_rr_mux #(
    parameter int NUM_MST        = 4,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    localparam int MIDX_W        = $clog2(NUM_MST),
    localparam int SLV_ID_WIDTH  = AXI_ID_WIDTH + MIDX_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MST*AXI_ID_WIDTH-1:0]   axi_mst_arid,
    input  logic [NUM_MST*AXI_ADDR_WIDTH-1:0] axi_mst_araddr,
    input  logic [NUM_MST-1:0]                axi_mst_arvalid,
    output logic [NUM_MST-1:0]                axi_mst_arready,
    output logic [SLV_ID_WIDTH-1:0]           axi_slv_arid,
    output logic [AXI_ADDR_WIDTH-1:0]         axi_slv_araddr,
    output logic                              axi_slv_arvalid,
    input  logic                              axi_slv_arready,
    output logic [MIDX_W-1:0]                 grant_idx
);

    logic [MIDX_W-1:0]         last_grant;
    logic [MIDX_W-1:0]         win;
    logic [MIDX_W-1:0]         cand;
    logic                      found;
    logic                      take;
    logic [AXI_ID_WIDTH-1:0]   mst_id   [NUM_MST];
    logic [AXI_ADDR_WIDTH-1:0] mst_addr [NUM_MST];

    for (genvar m = 0; m < NUM_MST; m++) begin : g_unpack
        assign mst_id[m]   = axi_mst_arid[m*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        assign mst_addr[m] = axi_mst_araddr[m*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    end

    // Scan starting one past the last winner so the last winner has lowest
    // priority; the modulo keeps unused index codes out when NUM_MST is not 2^n.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            cand = MIDX_W'((int'(last_grant) + k) % NUM_MST);
            if (!found && axi_mst_arvalid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Accept whenever the output slot is empty or being drained this cycle,
    // which gives back-to-back beats with no bubble.
    assign take = found && (!axi_slv_arvalid || axi_slv_arready);

    always_comb begin
        axi_mst_arready = '0;
        if (take && !rst) begin
            axi_mst_arready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            axi_slv_arvalid <= 1'b0;
            axi_slv_arid    <= '0;
            axi_slv_araddr  <= '0;
            grant_idx       <= '0;
            last_grant      <= MIDX_W'(NUM_MST - 1);
        end else if (take) begin
            axi_slv_arvalid <= 1'b1;
            axi_slv_arid    <= {win, mst_id[win]};
            axi_slv_araddr  <= mst_addr[win];
            grant_idx       <= win;
            last_grant      <= win;
        end else if (axi_slv_arvalid && axi_slv_arready) begin
            axi_slv_arvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_ar_rr_mux.sv
// tb/tb_axi_ar_rr_mux.sv - randomized and directed bench for axi_ar_rr_mux

module tb_axi_ar_rr_mux;

    localparam int N   = 4;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int MW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*IDW-1:0]  mst_arid;
    logic [N*AW-1:0]   mst_araddr;
    logic [N-1:0]      mst_arvalid;
    logic [N-1:0]      mst_arready;
    logic [MW+IDW-1:0] slv_arid;
    logic [AW-1:0]     slv_araddr;
    logic              slv_arvalid;
    logic              slv_arready;
    logic [MW-1:0]     grant_idx;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int                m_ptr;
    bit                m_full;
    logic [MW+IDW-1:0] m_id;
    logic [AW-1:0]     m_addr;
    int                m_gidx;

    always #5 clk = ~clk;

    axi_ar_rr_mux #(.NUM_MST(N), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .axi_mst_arid(mst_arid), .axi_mst_araddr(mst_araddr),
        .axi_mst_arvalid(mst_arvalid), .axi_mst_arready(mst_arready),
        .axi_slv_arid(slv_arid), .axi_slv_araddr(slv_araddr),
        .axi_slv_arvalid(slv_arvalid), .axi_slv_arready(slv_arready),
        .grant_idx(grant_idx)
    );

    // requester closest (in rotation distance) after the last grant wins
    function automatic int pick();
        int best = -1;
        int bd = N;
        for (int m = 0; m < N; m++) begin
            int d;
            d = (m - m_ptr - 1 + 2*N) % N;
            if (mst_arvalid[m] && d < bd) begin
                bd = d;
                best = m;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = pick();
        if (rst || w < 0 || (m_full && !slv_arready)) return '0;
        return N'(1) << w;
    endfunction

    task automatic set_payload(input int m);
        mst_arid[m*IDW +: IDW] = IDW'($urandom);
        mst_araddr[m*AW +: AW] = $urandom;
    endtask

    // advance model and DUT by one clock; returns at the following negedge
    task automatic tick();
        int w;
        w = pick();
        if (rst) begin
            m_full = 0; m_ptr = N - 1; m_id = '0; m_addr = '0; m_gidx = 0;
        end else if (w >= 0 && (!m_full || slv_arready)) begin
            m_full = 1;
            m_id   = {MW'(w), mst_arid[w*IDW +: IDW]};
            m_addr = mst_araddr[w*AW +: AW];
            m_ptr  = w;
            m_gidx = w;
        end else if (m_full && slv_arready) begin
            m_full = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; mst_arvalid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mst_arvalid = '0; slv_arready = 1'b0;
        for (int m = 0; m < N; m++) set_payload(m);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (slv_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid: got %b want 0", slv_arvalid); end
            n_vec++; if (mst_arready !== '0) begin n_err++; $display("FAIL reset_arready: got %b want 0", mst_arready); end
            n_vec++; if (grant_idx !== '0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
            n_vec++; if (slv_arid !== '0 || slv_araddr !== '0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", slv_arid, slv_araddr); end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        slv_arready = 1'b1;
        mst_arid[2*IDW +: IDW] = 4'h5;
        mst_araddr[2*AW +: AW] = 32'h0000_1000;
        mst_arvalid = 4'b0100;
        #1;
        n_vec++; if (mst_arready !== 4'b0100) begin n_err++; $display("FAIL single_arready: got %b want 0100", mst_arready); end
        tick();
        mst_arvalid = '0;
        n_vec++; if (slv_arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid: got %b want 1", slv_arvalid); end
        n_vec++; if (slv_arid !== 6'h25) begin n_err++; $display("FAIL single_arid: got %h want 25", slv_arid); end
        n_vec++; if (slv_araddr !== 32'h0000_1000) begin n_err++; $display("FAIL single_araddr: got %h want 00001000", slv_araddr); end
        n_vec++; if (grant_idx !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d want 2", grant_idx); end
        #1;
        n_vec++; if (mst_arready !== '0) begin n_err++; $display("FAIL idle_arready: got %b want 0", mst_arready); end
        tick();
        n_vec++; if (slv_arvalid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", slv_arvalid); end
    endtask

    task automatic test_round_robin();
        int ord [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        slv_arready = 1'b1;
        mst_arvalid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            for (int m = 0; m < N; m++) set_payload(m);
            #1;
            n_vec++; if (mst_arready !== N'(1) << ord[i]) begin n_err++; $display("FAIL rr_arready[%0d]: got %b want %b", i, mst_arready, N'(1) << ord[i]); end
            tick();
            n_vec++; if (slv_arvalid !== 1'b1 || grant_idx !== MW'(ord[i])) begin n_err++; $display("FAIL rr_beat[%0d]: got v=%b g=%0d want v=1 g=%0d", i, slv_arvalid, grant_idx, ord[i]); end
            n_vec++; if (slv_arid !== m_id || slv_araddr !== m_addr) begin n_err++; $display("FAIL rr_data[%0d]: got %h/%h want %h/%h", i, slv_arid, slv_araddr, m_id, m_addr); end
        end
        mst_arvalid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [IDW-1:0] id1, id3;
        logic [AW-1:0]  a1;
        do_reset();
        slv_arready = 1'b0;
        for (int m = 0; m < N; m++) set_payload(m);
        id1 = mst_arid[1*IDW +: IDW];
        id3 = mst_arid[3*IDW +: IDW];
        a1  = mst_araddr[1*AW +: AW];
        mst_arvalid = 4'b1010;
        #1;
        n_vec++; if (mst_arready !== 4'b0010) begin n_err++; $display("FAIL bp_first: got %b want 0010", mst_arready); end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (slv_arvalid !== 1'b1 || slv_arid !== {2'd1, id1} || slv_araddr !== a1) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b %h/%h want v=1 %h/%h", i, slv_arvalid, slv_arid, slv_araddr, {2'd1, id1}, a1); end
            #1;
            n_vec++; if (mst_arready !== '0) begin n_err++; $display("FAIL bp_stall_ready[%0d]: got %b want 0", i, mst_arready); end
            tick();
        end
        slv_arready = 1'b1;
        #1;
        n_vec++; if (mst_arready !== 4'b1000) begin n_err++; $display("FAIL bp_release: got %b want 1000", mst_arready); end
        tick();
        n_vec++; if (slv_arvalid !== 1'b1 || slv_arid !== {2'd3, id3} || grant_idx !== 2'd3) begin n_err++; $display("FAIL bp_next: got v=%b id=%h g=%0d want v=1 id=%h g=3", slv_arvalid, slv_arid, grant_idx, {2'd3, id3}); end
        mst_arvalid = '0;
        tick();
    endtask

    task automatic test_wrap_skip();
        int ord [4] = '{0, 2, 0, 2};
        do_reset();
        slv_arready = 1'b1;
        mst_arvalid = 4'b1000;
        tick();
        n_vec++; if (grant_idx !== 2'd3) begin n_err++; $display("FAIL wrap_setup: got %0d want 3", grant_idx); end
        mst_arvalid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (mst_arready !== N'(1) << ord[i]) begin n_err++; $display("FAIL wrap_arready[%0d]: got %b want %b", i, mst_arready, N'(1) << ord[i]); end
            tick();
            n_vec++; if (grant_idx !== MW'(ord[i]) || slv_arid[IDW +: MW] !== MW'(ord[i])) begin n_err++; $display("FAIL wrap_grant[%0d]: got %0d/%0d want %0d", i, grant_idx, slv_arid[IDW +: MW], ord[i]); end
        end
        mst_arvalid = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        slv_arready = 1'b0;
        mst_arvalid = 4'b0100;
        tick();
        n_vec++; if (slv_arvalid !== 1'b1) begin n_err++; $display("FAIL mr_full: got %b want 1", slv_arvalid); end
        mst_arvalid = 4'b1111;
        rst = 1'b1;
        #1;
        n_vec++; if (mst_arready !== '0) begin n_err++; $display("FAIL mr_ready_in_reset: got %b want 0", mst_arready); end
        tick();
        rst = 1'b0;
        mst_arvalid = '0;
        n_vec++; if (slv_arvalid !== 1'b0) begin n_err++; $display("FAIL mr_discard: got %b want 0", slv_arvalid); end
        mst_arvalid = 4'b1010;
        #1;
        n_vec++; if (mst_arready !== 4'b0010) begin n_err++; $display("FAIL mr_first_grant: got %b want 0010", mst_arready); end
        tick();
        n_vec++; if (grant_idx !== 2'd1 || slv_arid[IDW +: MW] !== 2'd1) begin n_err++; $display("FAIL mr_grant_idx: got %0d/%0d want 1", grant_idx, slv_arid[IDW +: MW]); end
        mst_arvalid = '0;
        slv_arready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        logic [N-1:0] er;
        acc = '1;
        for (int c = 0; c < 400; c++) begin
            n_vec++; if (slv_arvalid !== m_full || grant_idx !== MW'(m_gidx)) begin n_err++; $display("FAIL rnd_state[%0d]: got v=%b g=%0d want v=%b g=%0d", c, slv_arvalid, grant_idx, m_full, m_gidx); end
            if (m_full) begin
                n_vec++; if (slv_arid !== m_id || slv_araddr !== m_addr) begin n_err++; $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", c, slv_arid, slv_araddr, m_id, m_addr); end
            end
            // a pending request stays asserted with a stable payload until accepted
            for (int m = 0; m < N; m++) begin
                if (!mst_arvalid[m] || acc[m]) begin
                    mst_arvalid[m] = ($urandom_range(0, 2) != 0);
                    set_payload(m);
                end
            end
            slv_arready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            n_vec++; if (mst_arready !== er) begin n_err++; $display("FAIL rnd_arready[%0d]: got %b want %b", c, mst_arready, er); end
            acc = er;
            tick();
        end
        mst_arvalid = '0;
        slv_arready = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mst_arid = '0; mst_araddr = '0; mst_arvalid = '0; slv_arready = 1'b0;
        m_ptr = N - 1; m_full = 0; m_id = '0; m_addr = '0; m_gidx = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
